// File: rtl/data_memory_arbiter.sv
// rtl/data_memory_arbiter.sv - two-port round-robin arbiter in front of the single-port data memory
module data_memory_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t              state;
    logic                last_grant;
    logic                grant_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;

    logic                winner;
    logic                win_we;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_wdata;

    // A tie goes to port 0 under fixed priority, otherwise to the port not granted last.
    always_comb begin
        winner = req1;
        if (req0 && req1) begin
            winner = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
        end
        win_we    = winner ? we1    : we0;
        win_addr  = winner ? addr1  : addr0;
        win_wdata = winner ? wdata1 : wdata0;
    end

    // Memory strobes come straight from the command registers so a reset clears them at once.
    assign mem_read  = (state == ACCESS) && !we_q;
    assign mem_write = (state == ACCESS) && we_q;
    assign mem_addr  = (state == ACCESS) ? addr_q  : '0;
    assign mem_wdata = (state == ACCESS) ? wdata_q : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        grant_q    <= winner;
                        last_grant <= winner;
                        we_q       <= win_we;
                        addr_q     <= win_addr;
                        wdata_q    <= win_wdata;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!we_q) begin
                        if (grant_q) rdata1 <= mem_rdata;
                        else         rdata0 <= mem_rdata;
                    end
                    ack0  <= ~grant_q;
                    ack1  <= grant_q;
                    state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb/tb_data_memory_arbiter.sv - randomized and directed self-checking bench for data_memory_arbiter
module tb_data_memory_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0 is round-robin, instance 1 is fixed priority.
    logic       reset [2];
    logic       req0 [2], req1 [2], we0 [2], we1 [2];
    logic [7:0] addr0 [2], addr1 [2], wdata0 [2], wdata1 [2];
    logic       ack0 [2], ack1 [2], mem_read [2], mem_write [2];
    logic [7:0] rdata0 [2], rdata1 [2], mem_addr [2], mem_wdata [2], mem_rdata [2];

    logic [7:0] mem [2][256];
    assign mem_rdata[0] = mem_read[0] ? mem[0][mem_addr[0]] : 8'h00;
    assign mem_rdata[1] = mem_read[1] ? mem[1][mem_addr[1]] : 8'h00;

    data_memory_arbiter #(.ADDR_W(8), .DATA_W(8), .FIXED_PRIO(0)) dut_rr (
        .clk(clk), .reset(reset[0]),
        .req0(req0[0]), .we0(we0[0]), .addr0(addr0[0]), .wdata0(wdata0[0]),
        .req1(req1[0]), .we1(we1[0]), .addr1(addr1[0]), .wdata1(wdata1[0]),
        .ack0(ack0[0]), .ack1(ack1[0]), .rdata0(rdata0[0]), .rdata1(rdata1[0]),
        .mem_read(mem_read[0]), .mem_write(mem_write[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
    );

    data_memory_arbiter #(.ADDR_W(8), .DATA_W(8), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .reset(reset[1]),
        .req0(req0[1]), .we0(we0[1]), .addr0(addr0[1]), .wdata0(wdata0[1]),
        .req1(req1[1]), .we1(we1[1]), .addr1(addr1[1]), .wdata1(wdata1[1]),
        .ack0(ack0[1]), .ack1(ack1[1]), .rdata0(rdata0[1]), .rdata1(rdata1[1]),
        .mem_read(mem_read[1]), .mem_write(mem_write[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
    );

    int checks = 0;
    int errors = 0;

    // Transaction-level model: cycles elapsed since the current grant (0 = none in flight).
    int         since_grant [2];
    logic       win [2], cwe [2], lastg [2];
    logic [7:0] caddr [2], cwd [2], er0 [2], er1 [2];
    logic [7:0] ref_mem [2][256];
    logic       pw [2];
    logic [7:0] pa [2], pd [2];

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d t=%0t got %0h expected %0h", name, i, $time, act, exp);
        end
    endtask

    task automatic model_reset(input int i);
        since_grant[i] = 0;
        lastg[i] = 1'b1;
        win[i] = 1'b0; cwe[i] = 1'b0; caddr[i] = 8'h00; cwd[i] = 8'h00;
        er0[i] = 8'h00; er1[i] = 8'h00;
    endtask

    task automatic model_step(input int i);
        logic w;
        if (reset[i]) begin
            model_reset(i);
            return;
        end
        if (since_grant[i] == 0) begin
            if (req0[i] || req1[i]) begin
                if (req0[i] && req1[i]) w = (i == 1) ? 1'b0 : !lastg[i];
                else                    w = req1[i];
                win[i]   = w;
                lastg[i] = w;
                cwe[i]   = w ? we1[i] : we0[i];
                caddr[i] = w ? addr1[i] : addr0[i];
                cwd[i]   = w ? wdata1[i] : wdata0[i];
                since_grant[i] = 1;
            end
        end else if (since_grant[i] == 1) begin
            if (cwe[i])      ref_mem[i][caddr[i]] = cwd[i];
            else if (win[i]) er1[i] = ref_mem[i][caddr[i]];
            else             er0[i] = ref_mem[i][caddr[i]];
            since_grant[i] = 2;
        end else begin
            since_grant[i] = 0;
        end
    endtask

    task automatic check(input int i);
        logic acc;
        acc = (since_grant[i] == 1);
        chk("ack0", i, ack0[i], since_grant[i] == 2 && !win[i]);
        chk("ack1", i, ack1[i], since_grant[i] == 2 && win[i]);
        chk("mem_read", i, mem_read[i], acc && !cwe[i]);
        chk("mem_write", i, mem_write[i], acc && cwe[i]);
        chk("mem_addr", i, mem_addr[i], acc ? caddr[i] : 8'h00);
        chk("mem_wdata", i, mem_wdata[i], acc ? cwd[i] : 8'h00);
        chk("rdata0", i, rdata0[i], er0[i]);
        chk("rdata1", i, rdata1[i], er1[i]);
    endtask

    // One clock: advance the model on the current inputs, commit memory writes, then compare.
    task automatic step();
        for (int i = 0; i < 2; i++) begin
            model_step(i);
            pw[i] = mem_write[i]; pa[i] = mem_addr[i]; pd[i] = mem_wdata[i];
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) if (pw[i]) mem[i][pa[i]] = pd[i];
        #2;
        for (int i = 0; i < 2; i++) check(i);
    endtask

    task automatic idle_inputs(input int i);
        req0[i] = 0; req1[i] = 0; we0[i] = 0; we1[i] = 0;
        addr0[i] = 0; addr1[i] = 0; wdata0[i] = 0; wdata1[i] = 0;
    endtask

    task automatic drv(input logic acked, inout logic r, inout logic w,
                       inout logic [7:0] a, inout logic [7:0] d);
        if (r && acked) begin
            r = 1'b0;
        end else if (!r) begin
            if ($urandom_range(0, 2) == 0) begin
                r = 1'b1;
                w = 1'($urandom_range(0, 1));
                a = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 7));
                d = 8'($urandom);
            end
        end else if ($urandom_range(0, 15) == 0) begin
            a = 8'($urandom);
            d = 8'($urandom);
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 256; k++) begin
                mem[i][k] = 8'($urandom);
                ref_mem[i][k] = mem[i][k];
            end
            reset[i] = 1'b1;
            idle_inputs(i);
            model_reset(i);
        end
        repeat (2) @(posedge clk);
        #2;
        reset[0] = 1'b0; reset[1] = 1'b0;
        for (int i = 0; i < 2; i++) check(i);

        // Single read after reset
        mem[0][8'h10] = 8'hA5; ref_mem[0][8'h10] = 8'hA5;
        req0[0] = 1; we0[0] = 0; addr0[0] = 8'h10;
        step();
        chk("lit_read_mem_read", 0, mem_read[0], 1);
        chk("lit_read_mem_addr", 0, mem_addr[0], 8'h10);
        step();
        chk("lit_read_ack0", 0, ack0[0], 1);
        chk("lit_read_rdata0", 0, rdata0[0], 8'hA5);
        chk("lit_read_ack1", 0, ack1[0], 0);
        req0[0] = 0;
        step();

        // Write then read on port 1 at the top address
        req1[0] = 1; we1[0] = 1; addr1[0] = 8'hFF; wdata1[0] = 8'h3C;
        step();
        chk("lit_wr_mem_write", 0, mem_write[0], 1);
        step();
        chk("lit_wr_mem_write_off", 0, mem_write[0], 0);
        req1[0] = 0;
        step();
        req1[0] = 1; we1[0] = 0;
        step();
        step();
        chk("lit_rd_ack1", 0, ack1[0], 1);
        chk("lit_rd_rdata1", 0, rdata1[0], 8'h3C);
        chk("lit_rd_rdata0_kept", 0, rdata0[0], 8'hA5);
        req1[0] = 0;
        step();

        // Contention from reset: both held permanently
        reset[0] = 1; #1; reset[0] = 0;
        model_reset(0);
        req0[0] = 1; req1[0] = 1; addr0[0] = 8'h01; addr1[0] = 8'h02;
        for (int c = 1; c <= 9; c++) begin
            step();
            if (c == 2) chk("lit_tie_ack0_c2", 0, ack0[0], 1);
            if (c == 5) chk("lit_tie_ack1_c5", 0, ack1[0], 1);
            if (c == 8) chk("lit_tie_ack0_c8", 0, ack0[0], 1);
        end
        req0[0] = 0; req1[0] = 0;
        repeat (2) step();

        // Fixed priority: port 1 waits until req0 drops
        req0[1] = 1; req1[1] = 1; addr0[1] = 8'h05; addr1[1] = 8'h06;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c == 2) chk("lit_fp_ack0_c2", 1, ack0[1], 1);
            if (c == 5) begin
                chk("lit_fp_ack0_c5", 1, ack0[1], 1);
                req0[1] = 0;
            end
            if (c == 8) chk("lit_fp_ack1_c8", 1, ack1[1], 1);
        end
        req1[1] = 0;
        repeat (2) step();

        // Reset in the ACCESS cycle of a write
        req0[0] = 1; we0[0] = 1; addr0[0] = 8'h20; wdata0[0] = 8'h77;
        step();
        chk("lit_rst_wr_active", 0, mem_write[0], 1);
        #1 reset[0] = 1;
        #1 chk("lit_rst_wr_dropped", 0, mem_write[0], 0);
        model_reset(0);
        idle_inputs(0);
        repeat (3) step();
        reset[0] = 0;
        step();
        chk("lit_rst_mem_kept", 0, mem[0][8'h20], ref_mem[0][8'h20]);
        req0[0] = 1; req1[0] = 1; we0[0] = 0; we1[0] = 0;
        step();
        step();
        chk("lit_rst_tie_ack0", 0, ack0[0], 1);
        idle_inputs(0);
        repeat (2) step();

        // Randomized traffic on both instances
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++) begin
                drv(since_grant[i] == 2 && !win[i], req0[i], we0[i], addr0[i], wdata0[i]);
                drv(since_grant[i] == 2 && win[i], req1[i], we1[i], addr1[i], wdata1[i]);
            end
            step();
        end
        for (int i = 0; i < 2; i++) idle_inputs(i);
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
